// File: rtl/flex_stp_framer_if.sv
// Bus bundle for flex_stp_framer: serial input side, direction/clear controls,
// parallel/word outputs and the word_valid/word_ready handshake.
interface flex_stp_framer_if #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned LANES    = 1
);
    localparam int unsigned BEATS = NUM_BITS / LANES;
    localparam int unsigned CW    = (BEATS > 2) ? $clog2(BEATS) : 1;

    logic                shift_enable;
    logic [LANES-1:0]    serial_in;
    logic                shift_msb;
    logic                clear;
    logic                word_ready;
    logic [NUM_BITS-1:0] parallel_out;
    logic [NUM_BITS-1:0] word_out;
    logic                word_valid;
    logic [CW-1:0]       beat_cnt;
    logic                overrun;

    // Producer / consumer side
    modport master (
        output shift_enable, serial_in, shift_msb, clear, word_ready,
        input  parallel_out, word_out, word_valid, beat_cnt, overrun
    );

    // Framer side
    modport slave (
        input  shift_enable, serial_in, shift_msb, clear, word_ready,
        output parallel_out, word_out, word_valid, beat_cnt, overrun
    );
endinterface

// File: rtl/flex_stp_framer.sv
// Serial-to-parallel framer: shifts LANES bits per beat, assembles NUM_BITS
// words, and hands each finished word to a held register with valid/ready.
module flex_stp_framer #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned LANES    = 1
) (
    input  logic            clk,
    input  logic            rst,
    flex_stp_framer_if.slave bus
);
    localparam int unsigned BEATS = NUM_BITS / LANES;
    localparam int unsigned CW    = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [NUM_BITS-1:0] par_q, par_d;
    logic [NUM_BITS-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovr_q, ovr_d;
    logic                dir_q, dir_d;

    logic [LANES-1:0]    serial_rev;
    logic                dir_eff;
    logic [NUM_BITS-1:0] shifted;

    // Bit-reverse the beat so the earliest bit lands at the lower index in LSB mode
    always_comb begin
        serial_rev = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            serial_rev[i] = bus.serial_in[LANES-1-i];
        end
    end

    // Post-shift value; direction comes from shift_msb on the first beat, else the latch
    always_comb begin
        dir_eff = (cnt_q == '0) ? bus.shift_msb : dir_q;
        if (dir_eff) begin
            shifted = {par_q[NUM_BITS-LANES-1:0], bus.serial_in};
        end else begin
            shifted = {serial_rev, par_q[NUM_BITS-1:LANES]};
        end
    end

    // Next-state: consumption, clear/shift, word completion and overrun
    always_comb begin
        par_d   = par_q;
        word_d  = word_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ovr_d   = 1'b0;
        dir_d   = dir_q;

        if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
        end

        if (bus.clear) begin
            par_d = '1;
            cnt_d = '0;
        end else if (bus.shift_enable) begin
            par_d = shifted;
            dir_d = dir_eff;
            if (cnt_q == LAST_BEAT) begin
                cnt_d = '0;
                if (!valid_q || bus.word_ready) begin
                    word_d  = shifted;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q   <= '1;
            word_q  <= '1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            par_q   <= par_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.parallel_out = par_q;
    assign bus.word_out     = word_q;
    assign bus.word_valid   = valid_q;
    assign bus.beat_cnt     = cnt_q;
    assign bus.overrun      = ovr_q;
endmodule

// File: doc/flex_stp_framer.md
Name: flex_stp_framer

Overview:
Parametrised serial-to-parallel deserializer: the next generation of the team's flexible shift register.
- Accepts LANES bits per shift and counts beats until a full NUM_BITS word is assembled.
- Captures each completed word into a holding register with a valid/ready handshake. Shift direction is selectable at run time, and overrun is flagged.
- Sits between bit-level receive logic (e.g. USB/UART RX) and word-level consumers (FIFO or controller FSM).

Parameters:
NUM_BITS, 8, word width; must be a multiple of LANES and at least 2*LANES.
LANES, 1, serial bits accepted per shift_enable beat.
BEATS (localparam), NUM_BITS/LANES, shifts per word.
CW (localparam), max(1, clog2(BEATS)), beat counter width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
shift_enable  input  1  shift serial_in into the register this edge.
serial_in  input  LANES  new bits; serial_in[LANES-1] is the earliest bit of the beat.
shift_msb  input  1  1 = shift toward MSB (first bit ends at MSB); 0 = shift toward LSB (first bit ends at LSB).
clear  input  1  synchronous word restart; discards the partial word.
word_ready  input  1  consumer accepts word_out this edge.
parallel_out  output  NUM_BITS  live shift register contents.
word_out  output  NUM_BITS  last completed word, held.
word_valid  output  1  word_out holds an unconsumed word.
beat_cnt  output  CW  beats received in the current word (0..BEATS-1).
overrun  output  1  one-cycle pulse: completed word dropped.

Behaviour:
- All state is updated on the rising edge of clk. Every output is registered.
- Reset (rst=1 at an edge) has priority over everything:
  - parallel_out = all 1s, word_out = all 1s.
  - word_valid = 0, beat_cnt = 0, overrun = 0.
  - Latched direction = MSB.
  - Reset mid-word discards the partial word and any held word.
- Direction latch:
  - shift_msb is sampled on the beat where beat_cnt==0 and shift_enable=1.
  - It is held for the rest of that word. Changes mid-word have no effect until the next word.
- Shift on shift_enable=1:
  - MSB mode: parallel_out <= {parallel_out[NUM_BITS-LANES-1:0], serial_in}.
  - LSB mode: parallel_out <= {bit-reversed serial_in, parallel_out[NUM_BITS-1:LANES]}. The earliest bit lands at the lower index.
  - beat_cnt increments and wraps from BEATS-1 to 0.
- shift_enable=0: parallel_out and beat_cnt hold.
- Word completion (shift_enable=1 and beat_cnt==BEATS-1):
  - The post-shift value is the completed word.
  - If word_valid==0, or word_ready==1 on the same edge: word_out <= completed word and word_valid=1 from the next cycle. Latency is 1 clock after the final beat's edge.
  - If word_valid==1 and word_ready==0: the new word is dropped, word_out is unchanged, and overrun=1 for exactly one cycle.
  - beat_cnt returns to 0 in all completion cases.
  - parallel_out keeps the completed word until it is shifted over.
- Handshake:
  - word_valid stays high until an edge with word_ready=1.
  - Consumption with no simultaneous completion: word_valid <= 0 and word_out holds its value.
  - word_ready while word_valid=0 is ignored.
- clear=1 (and rst=0):
  - parallel_out = all 1s, beat_cnt = 0.
  - clear overrides shift_enable on the same edge; no completion occurs.
  - word_out, word_valid and the handshake are unaffected; consumption still proceeds on that edge.
- overrun is 0 on every cycle not described above.

Test Plan:
- NUM_BITS=8, LANES=1, shift_msb=1, bits 1,0,1,1,0,0,1,0 on consecutive enables, word_ready=0 → word_out=8'hB2 and word_valid=1 one cycle after the 8th shift. beat_cnt sequence is 1..7 then 0.
- Same bits, shift_msb=0 → word_out=8'h4D. Toggling shift_msb after the 3rd beat does not change the result.
- NUM_BITS=8, LANES=2, MSB mode, serial_in 2'b10, 2'b11, 2'b00, 2'b01 → word_out=8'hB1.
- Hold word_ready=0 and complete a second word 8'h0F while 8'hB2 is held → overrun pulses for 1 cycle and word_out stays 8'hB2. Then assert word_ready for 1 cycle → word_valid drops.
- word_ready=1 on the same edge as a completion while word_valid=1 → new word loaded, word_valid stays 1, overrun stays 0.
- Assert clear after 5 beats, and separately rst after 5 beats, with shift_enable=1 → beat_cnt=0 and parallel_out=8'hFF. Eight further beats give a correct word. After rst, word_valid=0 and word_out=8'hFF.
